// File: rtl/ft_cmd_decoder_if.sv
// Bus bundle between ft_cmd_decoder, the FT245 bridge FIFOs and the camera register block.
// master = decoder side, slave = FIFO/register side.
interface ft_cmd_decoder_if;
    logic        rx_rempty;
    logic [7:0]  rx_rdata;
    logic        rx_rinc;
    logic        tx_wfull;
    logic [7:0]  tx_wdata;
    logic        tx_winc;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;

    modport master (
        input  rx_rempty, rx_rdata, tx_wfull,
        output rx_rinc, tx_wdata, tx_winc, reg_addr, reg_wdata, reg_we
    );

    modport slave (
        output rx_rempty, rx_rdata, tx_wfull,
        input  rx_rinc, tx_wdata, tx_winc, reg_addr, reg_wdata, reg_we
    );
endinterface

// File: rtl/ft_cmd_decoder.sv
// Host command decoder: frames SYNC/ADDR/DHI/DLO/CHK bytes from the RX FIFO into register writes
// and acks each frame into the TX FIFO. Define CMD_TIMEOUT_EN to abort stalled partial frames.
module ft_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] ACK_OK    = 8'h4B,
    parameter logic [7:0] ACK_ERR   = 8'h45
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4095
`endif
) (
    input  logic             clk,
    input  logic             rst,
    ft_cmd_decoder_if.master bus,
    output logic             frame_err,
    output logic [7:0]       err_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        StHunt,
        StAddr,
        StDhi,
        StDlo,
        StChk,
        StExec,
        StAck
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  addr_sh_q, addr_sh_d;
    logic [7:0]  dhi_sh_q, dhi_sh_d;
    logic [7:0]  dlo_sh_q, dlo_sh_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic [7:0]  ack_q, ack_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        in_frame;
    logic        pop;
    logic        timeout_hit;

    assign in_frame = state_q inside {StAddr, StDhi, StDlo, StChk};
    assign pop      = !bus.rx_rempty && (state_q == StHunt || in_frame);

`ifdef CMD_TIMEOUT_EN
    localparam logic [11:0] TimeoutLast = 12'(TIMEOUT_CYCLES - 1);

    logic [11:0] idle_cnt_q, idle_cnt_d;

    // Counts empty-FIFO cycles inside a partial frame; any pop or leaving the frame clears it.
    assign timeout_hit = in_frame && bus.rx_rempty && (idle_cnt_q == TimeoutLast);
    assign idle_cnt_d  = (in_frame && bus.rx_rempty && !timeout_hit) ? idle_cnt_q + 12'd1 : 12'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_sh_d   = addr_sh_q;
        dhi_sh_d    = dhi_sh_q;
        dlo_sh_d    = dlo_sh_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        ack_d       = ack_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (pop && bus.rx_rdata == SYNC_BYTE) state_d = StAddr;
            end
            StAddr: begin
                if (pop) begin
                    addr_sh_d = bus.rx_rdata;
                    state_d   = StDhi;
                end
            end
            StDhi: begin
                if (pop) begin
                    dhi_sh_d = bus.rx_rdata;
                    state_d  = StDlo;
                end
            end
            StDlo: begin
                if (pop) begin
                    dlo_sh_d = bus.rx_rdata;
                    state_d  = StChk;
                end
            end
            StChk: begin
                if (pop) begin
                    if (bus.rx_rdata == (addr_sh_q ^ dhi_sh_q ^ dlo_sh_q)) begin
                        reg_addr_d  = addr_sh_q;
                        reg_wdata_d = {dhi_sh_q, dlo_sh_q};
                        ack_d       = ACK_OK;
                        state_d     = StExec;
                    end else begin
                        ack_d       = ACK_ERR;
                        frame_err_d = 1'b1;
                        state_d     = StAck;
                    end
                end
            end
            StExec: state_d = StAck;
            StAck: begin
                if (!bus.tx_wfull) state_d = StHunt;
            end
            default: state_d = StHunt;
        endcase

        if (timeout_hit) begin
            state_d     = StHunt;
            frame_err_d = 1'b1;
        end

        err_count_d = (frame_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            addr_sh_q   <= '0;
            dhi_sh_q    <= '0;
            dlo_sh_q    <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            ack_q       <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_sh_q   <= addr_sh_d;
            dhi_sh_q    <= dhi_sh_d;
            dlo_sh_q    <= dlo_sh_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            ack_q       <= ack_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.rx_rinc   = pop;
    assign bus.reg_we    = (state_q == StExec);
    assign bus.tx_winc   = (state_q == StAck) && !bus.tx_wfull;
    assign bus.tx_wdata  = (state_q == StAck) ? ack_q : 8'h00;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign frame_err     = frame_err_q;
    assign err_count     = err_count_q;
    assign busy          = (state_q != StHunt);

endmodule
